// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 9-bit RISC core: owns the PC, retire counter and per-state controls.
// Optional build macro SEQ_SELF_JUMP_HALT_EN: a jump to its own address parks the sequencer in HALT.
module instr_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ir_load,
  output logic [PC_W-1:0]  pc,
  input  logic             ri_type,
  input  logic [2:0]       rop,
  input  logic [1:0]       iop,
  input  logic [2:0]       imm_b,
  input  logic [4:0]       pcj_add,
  input  logic             rs_zero,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire_en;

  logic [PC_W-1:0] pc_inc, pc_branch, jump_target;
  assign pc_inc      = pc_reg + PC_W'(1);
  assign pc_branch   = pc_reg + PC_W'(1) + PC_W'(imm_b);
  assign jump_target = PC_W'(pcj_add);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (retire_en && retired_reg != '1)
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    retire_en  = 1'b0;
    ir_load    = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = FETCH;
      FETCH: begin
        ir_load    = 1'b1;
        state_next = DECODE;
      end
      DECODE: state_next = (ri_type && iop[1]) ? MEM : EXEC;
      EXEC: begin
        state_next = FETCH;
        retire_en  = 1'b1;
        pc_next    = pc_inc;
        if (!ri_type) begin
          if (rop == 3'b111) begin
            pc_next = jump_target;
`ifdef SEQ_SELF_JUMP_HALT_EN
            if (jump_target == pc_reg) state_next = HALT;
`endif
          end else begin
            reg_we = 1'b1;
          end
        end else begin
          case (iop)
            2'b00: if (rs_zero) pc_next = pc_branch;
            2'b01: begin
              reg_we = 1'b1;
              wb_sel = 2'd1;
            end
            default: ;
          endcase
        end
      end
      // Request and direction stay asserted every MEM cycle until the ack pulse.
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iop == 2'b11);
        if (dmem_ack) begin
          if (iop == 2'b11) begin
            pc_next    = pc_inc;
            retire_en  = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        reg_we     = 1'b1;
        wb_sel     = 2'd2;
        pc_next    = pc_inc;
        retire_en  = 1'b1;
        state_next = FETCH;
      end
      HALT: ;
      default: state_next = IDLE;
    endcase
  end

  assign pc      = pc_reg;
  assign retired = retired_reg;
  assign busy    = (state_reg != IDLE) && (state_reg != HALT);
`ifdef SEQ_SELF_JUMP_HALT_EN
  assign halted  = (state_reg == HALT);
`else
  assign halted  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed cases plus random instructions against a per-instruction model.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, ri_type, rs_zero, dmem_ack;
  logic [2:0]  rop, imm_b;
  logic [1:0]  iop;
  logic [4:0]  pcj_add;
  logic        ir_load, reg_we, dmem_req, dmem_we, busy, halted;
  logic [1:0]  wb_sel;
  logic [7:0]  pc;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_ret;

  instr_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ir_load(ir_load), .pc(pc),
    .ri_type(ri_type), .rop(rop), .iop(iop), .imm_b(imm_b), .pcj_add(pcj_add),
    .rs_zero(rs_zero), .reg_we(reg_we), .wb_sel(wb_sel), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .busy(busy), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge where FETCH is visible; returns at the next FETCH.
  task automatic run_instr(input logic rt, input logic [2:0] r, input logic [1:0] i,
                           input logic [2:0] im, input logic [4:0] pj, input logic rz,
                           input int wait_n);
    logic is_mem, is_j, is_bz, is_li, exp_we, saw_we, we_ok, busy_ok, done;
    logic [1:0] exp_sel, sel_seen;
    logic [7:0] nxt;
    int exp_lat, cyc, memc;
    is_mem = rt && i[1];
    is_j   = !rt && (r == 3'd7);
    is_bz  = rt && (i == 2'd0);
    is_li  = rt && (i == 2'd1);
    if (is_mem) begin
      exp_lat = ((i == 2'd3) ? 3 : 4) + wait_n;
      nxt     = exp_pc + 8'd1;
      exp_we  = (i == 2'd2);
      exp_sel = 2'd2;
    end else begin
      exp_lat = 3;
      exp_we  = !(is_j || is_bz);
      exp_sel = is_li ? 2'd1 : 2'd0;
      if (is_j)             nxt = {3'b000, pj};
      else if (is_bz && rz) nxt = exp_pc + 8'd1 + {5'b00000, im};
      else                  nxt = exp_pc + 8'd1;
    end
    ri_type = rt; rop = r; iop = i; imm_b = im; pcj_add = pj; rs_zero = rz;
    cyc = 1; memc = 0; saw_we = 0; sel_seen = 2'd0; we_ok = 1; busy_ok = 1; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (ir_load) done = 1;
      else begin
        cyc++;
        if (!busy) busy_ok = 0;
        if (reg_we) begin saw_we = 1; sel_seen = wb_sel; end
        if (dmem_req) begin
          memc++;
          if (dmem_we !== (i == 2'd3)) we_ok = 0;
          if (memc == wait_n + 1) dmem_ack = 1'b1;
        end
      end
    end
    chk("next_fetch_seen", done, 1);
    chk("latency", cyc, exp_lat);
    chk("pc", pc, nxt);
    chk("retired", retired, exp_ret + 16'd1);
    chk("reg_we_seen", saw_we, exp_we);
    chk("wb_sel", sel_seen, exp_we ? exp_sel : 2'd0);
    chk("mem_cycles", memc, is_mem ? wait_n + 1 : 0);
    chk("dmem_we", we_ok, 1);
    chk("busy_during_instr", busy_ok, 1);
    $display("instr rt=%0d rop=%0d iop=%0d imm=%0d pj=%0d rz=%0d wait=%0d: pc %0d -> %0d, %0d cycles",
             rt, r, i, im, pj, rz, wait_n, exp_pc, pc, cyc);
    exp_pc  = nxt;
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ir_load_after_start", ir_load, 1);
    chk("pc_at_start", pc, exp_pc);
  endtask

  initial begin
    logic rt, rz, done;
    logic [2:0] r, im;
    logic [1:0] i;
    logic [4:0] pj;
    int cyc;
    reset = 1'b1; start = 0; ri_type = 0; rs_zero = 0; dmem_ack = 0;
    rop = 0; iop = 0; imm_b = 0; pcj_add = 0;
    exp_pc = 8'd0; exp_ret = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_ctrl", {ir_load, reg_we, wb_sel, dmem_req, dmem_we, busy, halted}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_without_start", busy, 0);

    start_run();
    run_instr(0, 3'd0, 2'd0, 3'd0, 5'd0, 0, 0);    // ADD at 0
    run_instr(0, 3'd7, 2'd0, 3'd0, 5'd4, 0, 0);    // J 4
    run_instr(1, 3'd0, 2'd1, 3'd0, 5'd0, 0, 0);    // LI at 4
    run_instr(0, 3'd7, 2'd0, 3'd0, 5'd10, 0, 0);
    run_instr(1, 3'd0, 2'd0, 3'd3, 5'd0, 1, 0);    // BEQZ taken -> 14
    run_instr(0, 3'd7, 2'd0, 3'd0, 5'd10, 0, 0);
    run_instr(1, 3'd0, 2'd0, 3'd3, 5'd0, 0, 0);    // BEQZ not taken -> 11
    while (exp_pc < 8'd246) run_instr(1, 3'd0, 2'd0, 3'd7, 5'd0, 1, 0);
    while (exp_pc != 8'd254) run_instr(0, 3'd1, 2'd0, 3'd0, 5'd0, 0, 0);
    run_instr(1, 3'd0, 2'd0, 3'd3, 5'd0, 1, 0);    // wrap to 2
    run_instr(1, 3'd0, 2'd2, 3'd0, 5'd0, 0, 4);    // LD, 4 wait cycles
    run_instr(1, 3'd0, 2'd3, 3'd0, 5'd0, 0, 0);    // STR, immediate ack

    // Reset in the second MEM cycle of a load; a late ack must be ignored.
    ri_type = 1; iop = 2'd2;
    @(negedge clk);
    @(negedge clk);
    chk("ld_mem1_req", dmem_req, 1);
    @(negedge clk);
    chk("ld_mem2_req", dmem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_retired", retired, 0);
    chk("midrst_busy", busy, 0);
    exp_pc = 8'd0; exp_ret = 16'd0;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_busy", busy, 0);
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_pc", pc, 0);
    $display("reset during LD MEM: sequencer back in IDLE");

    start_run();
    for (int n = 0; n < 40; n++) begin
      rt = 1'($urandom); r = 3'($urandom); i = 2'($urandom);
      im = 3'($urandom); pj = 5'($urandom); rz = 1'($urandom);
      if (!rt && r == 3'd7 && {3'b000, pj} == exp_pc) pj = pj ^ 5'd1;
      run_instr(rt, r, i, im, pj, rz, int'($urandom_range(0, 3)));
    end

    run_instr(0, 3'd7, 2'd0, 3'd0, 5'd7, 0, 0);    // J 7
`ifdef SEQ_SELF_JUMP_HALT_EN
    ri_type = 0; rop = 3'd7; pcj_add = 5'd7;
    cyc = 1; done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (halted) done = 1;
    end
    chk("halt_reached", done, 1);
    chk("halt_latency", cyc, 4);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 7);
    chk("halt_retired", retired, exp_ret + 16'd1);
    repeat (6) @(negedge clk);
    chk("halt_retired_stable", retired, exp_ret + 16'd1);
    chk("halt_stays", halted, 1);
    chk("halt_no_fetch", ir_load, 0);
    $display("self-jump at 7: halted");
`else
    repeat (3) run_instr(0, 3'd7, 2'd0, 3'd0, 5'd7, 0, 0);
    chk("no_halt", halted, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
